// File: rtl/servo_ipd_mux.sv
// servo_ipd_mux
// Time-shared IPD servo controller (integral on error, proportional and
// derivative on measurement) serving NCH channels through one multiplier, with
// one glitch-free PWM output per channel.
//
// Ports
//   Clock_Nexys  system clock
//   Reset        asynchronous active-low reset
//   adc_valid    sample present
//   adc_ready    block can accept a sample (IDLE only)
//   adc_chan     channel tag of the sample
//   adc_data     raw offset-binary ADC sample
//   ref_bus      packed signed references, channel c at [c*REF_W +: REF_W]
//   done         one-cycle pulse while a channel update is written
//   done_chan    channel of the last update
//   err_chan     one-cycle pulse: sample dropped because of a bad tag
//   sat          sticky per-channel clamp flags
//   pwm_out      servo PWM outputs
//
// Build option
//   SERVO_IPD_DTERM_EN  defined: MUL_D state, KD path and y2 storage exist.
//                       undefined: MUL_P goes straight to SAT, KD is ignored.

module servo_ipd_mux #(
  parameter int NCH   = 4,
  parameter int ADC_W = 8,
  parameter int REF_W = 8,
  parameter int MAG   = 18,
  parameter int DEC   = 8,
  parameter int KI    = 256,
  parameter int KP    = 0,
  parameter int KD    = 0,
  parameter int PWM_W = 8,
  parameter int PRESC = 1,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 Clock_Nexys,
  input  logic                 Reset,
  input  logic                 adc_valid,
  output logic                 adc_ready,
  input  logic [CW-1:0]        adc_chan,
  input  logic [ADC_W-1:0]     adc_data,
  input  logic [NCH*REF_W-1:0] ref_bus,
  output logic                 done,
  output logic [CW-1:0]        done_chan,
  output logic                 err_chan,
  output logic [NCH-1:0]       sat,
  output logic [NCH-1:0]       pwm_out
);

  localparam int N  = MAG + DEC + 1;
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  localparam logic signed [N-1:0] C_KI     = N'(KI);
  localparam logic signed [N-1:0] C_KP     = N'(KP);
`ifdef SERVO_IPD_DTERM_EN
  localparam logic signed [N-1:0] C_KD     = N'(KD);
`endif
  localparam logic signed [N-1:0] C_MAX    = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] C_MIN    = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [N-1:0] C_LIM_HI = N'((2**(PWM_W-1) - 1) * (2**DEC));
  localparam logic signed [N-1:0] C_LIM_LO = N'(-(2**(PWM_W-1)) * (2**DEC));
  localparam logic [PWM_W-1:0]    C_HALF   = {1'b1, {(PWM_W-1){1'b0}}};
  localparam logic [CW:0]         C_NCH    = (CW+1)'(NCH);
  localparam logic [PW-1:0]       C_PLAST  = PW'(PRESC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MUL_I, S_MUL_P, S_MUL_D, S_SAT, S_WRITE
  } state_t;

  state_t r_state, w_state_next;

  logic [CW-1:0]           r_chan;
  logic [ADC_W-1:0]        r_adc;
  logic signed [N-1:0]     r_y, r_e, r_acc;
  logic [CW-1:0]           r_done_chan;
  logic                    r_err;
  logic [PW-1:0]           r_presc;
  logic [PWM_W-1:0]        r_cnt;

  logic                    w_accept, w_tag_ok, w_tick, w_wrap;
  logic signed [N-1:0]     w_u_arr  [NCH];
  logic signed [N-1:0]     w_y1_arr [NCH];
  logic signed [REF_W-1:0] w_ref_arr[NCH];
  logic signed [ADC_W-1:0] w_adc_s;
  logic signed [REF_W-1:0] w_ref_s;
  logic signed [N-1:0]     w_y_ld, w_r_ld, w_e_ld;
  logic signed [N-1:0]     w_y1, w_dy;
  logic signed [N-1:0]     w_mul_a, w_mul_b;
  logic signed [2*N-1:0]   w_prod, w_prod_sh;
  logic [N:0]              w_hi;
  logic signed [N-1:0]     w_prod_sat;
  logic [N:0]              w_sum_wide;
  logic signed [N-1:0]     w_sum;
  logic                    w_clamp_hi, w_clamp_lo;
  logic signed [N-1:0]     w_clamped;
  logic [PWM_W-1:0]        w_duty_new;
`ifdef SERVO_IPD_DTERM_EN
  logic signed [N-1:0]     w_y2_arr [NCH];
  logic signed [N-1:0]     w_y2, w_d2y;
`endif

  assign w_tag_ok  = {1'b0, adc_chan} < C_NCH;
  assign w_accept  = adc_valid && (r_state == S_IDLE);
  assign adc_ready = (r_state == S_IDLE);
  assign done      = (r_state == S_WRITE);
  assign done_chan = r_done_chan;
  assign err_chan  = r_err;

  // Flipping the MSB of an offset-binary sample yields its two's complement value.
  assign w_adc_s = {~r_adc[ADC_W-1], r_adc[ADC_W-2:0]};
  assign w_ref_s = w_ref_arr[r_chan];
  assign w_y_ld  = {{(N-ADC_W-DEC){w_adc_s[ADC_W-1]}}, w_adc_s, {DEC{1'b0}}};
  assign w_r_ld  = {{(N-REF_W-DEC){w_ref_s[REF_W-1]}}, w_ref_s, {DEC{1'b0}}};
  assign w_e_ld  = w_r_ld - w_y_ld;

  assign w_y1 = w_y1_arr[r_chan];
  assign w_dy = r_y - w_y1;
`ifdef SERVO_IPD_DTERM_EN
  assign w_y2  = w_y2_arr[r_chan];
  assign w_d2y = r_y - (w_y1 <<< 1) + w_y2;
`endif

  // FSM state register
  always_ff @(posedge Clock_Nexys or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (adc_valid && w_tag_ok) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_MUL_I;
      S_MUL_I: w_state_next = S_MUL_P;
`ifdef SERVO_IPD_DTERM_EN
      S_MUL_P: w_state_next = S_MUL_D;
`else
      S_MUL_P: w_state_next = S_SAT;
`endif
      S_MUL_D: w_state_next = S_SAT;
      S_SAT:   w_state_next = S_WRITE;
      S_WRITE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Shared multiplier operand select
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      S_MUL_I: begin w_mul_a = C_KI; w_mul_b = r_e;   end
      S_MUL_P: begin w_mul_a = C_KP; w_mul_b = w_dy;  end
`ifdef SERVO_IPD_DTERM_EN
      S_MUL_D: begin w_mul_a = C_KD; w_mul_b = w_d2y; end
`endif
      default: ;
    endcase
  end

  // Product rescaled by 2^-DEC; saturate when the discarded high bits are not
  // pure sign extension.
  always_comb begin
    w_prod     = w_mul_a * w_mul_b;
    w_prod_sh  = w_prod >>> DEC;
    w_hi       = w_prod_sh[2*N-1:N-1];
    w_prod_sat = w_prod_sh[N-1:0];
    if (!((&w_hi) || !(|w_hi)))
      w_prod_sat = w_prod_sh[2*N-1] ? C_MIN : C_MAX;
  end

  // Accumulate with one guard bit so the running sum saturates instead of wrapping.
  always_comb begin
    if (r_state == S_MUL_I)
      w_sum_wide = {r_acc[N-1], r_acc} + {w_prod_sat[N-1], w_prod_sat};
    else
      w_sum_wide = {r_acc[N-1], r_acc} - {w_prod_sat[N-1], w_prod_sat};
    w_sum = w_sum_wide[N-1:0];
    if (w_sum_wide[N] != w_sum_wide[N-1])
      w_sum = w_sum_wide[N] ? C_MIN : C_MAX;
  end

  assign w_clamp_hi = (r_acc > C_LIM_HI);
  assign w_clamp_lo = (r_acc < C_LIM_LO);
  assign w_clamped  = w_clamp_hi ? C_LIM_HI : (w_clamp_lo ? C_LIM_LO : r_acc);

  // u is already clamped to the PWM range, so adding half scale to the integer
  // part is the same as inverting its MSB.
  assign w_duty_new = {~r_acc[DEC+PWM_W-1], r_acc[DEC +: PWM_W-1]};

  // Datapath registers
  always_ff @(posedge Clock_Nexys or negedge Reset) begin
    if (!Reset) begin
      r_chan      <= '0;
      r_adc       <= '0;
      r_y         <= '0;
      r_e         <= '0;
      r_acc       <= '0;
      r_done_chan <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_accept && !w_tag_ok;
      if (w_accept && w_tag_ok) begin
        r_chan <= adc_chan;
        r_adc  <= adc_data;
      end
      case (r_state)
        S_LOAD: begin
          r_y   <= w_y_ld;
          r_e   <= w_e_ld;
          r_acc <= w_u_arr[r_chan];
        end
        S_MUL_I, S_MUL_P, S_MUL_D: r_acc <= w_sum;
        S_SAT: begin
          r_acc       <= w_clamped;
          r_done_chan <= r_chan;
        end
        default: ;
      endcase
    end
  end

  // PWM prescaler and frame counter shared by all channels
  assign w_tick = (r_presc == C_PLAST);
  assign w_wrap = w_tick && (&r_cnt);

  always_ff @(posedge Clock_Nexys or negedge Reset) begin
    if (!Reset) begin
      r_presc <= '0;
      r_cnt   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Per-channel controller state, duty double buffer and PWM output
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic signed [N-1:0] r_u, r_y1;
      logic [PWM_W-1:0]    r_duty_sh, r_duty_act;
      logic                r_pwm, r_sat;
      logic                w_sel;

      assign w_sel         = (r_chan == CW'(gi));
      assign w_u_arr[gi]   = r_u;
      assign w_y1_arr[gi]  = r_y1;
      assign w_ref_arr[gi] = ref_bus[gi*REF_W +: REF_W];
      assign sat[gi]       = r_sat;
      assign pwm_out[gi]   = r_pwm;

      always_ff @(posedge Clock_Nexys or negedge Reset) begin
        if (!Reset) begin
          r_u        <= '0;
          r_y1       <= '0;
          r_duty_sh  <= C_HALF;
          r_duty_act <= C_HALF;
          r_pwm      <= 1'b0;
          r_sat      <= 1'b0;
        end else begin
          if (r_state == S_WRITE && w_sel) begin
            r_u       <= r_acc;
            r_y1      <= r_y;
            r_duty_sh <= w_duty_new;
          end
          if (r_state == S_SAT && w_sel && (w_clamp_hi || w_clamp_lo))
            r_sat <= 1'b1;
          // Active duty only changes at the frame boundary; a same-edge
          // WRITE lands in the shadow and is picked up one frame later.
          if (w_wrap) r_duty_act <= r_duty_sh;
          r_pwm <= (r_cnt < r_duty_act);
        end
      end

`ifdef SERVO_IPD_DTERM_EN
      logic signed [N-1:0] r_y2;
      assign w_y2_arr[gi] = r_y2;
      always_ff @(posedge Clock_Nexys or negedge Reset) begin
        if (!Reset)                              r_y2 <= '0;
        else if (r_state == S_WRITE && w_sel)    r_y2 <= r_y1;
      end
`endif
    end
  endgenerate

endmodule

// File: tb/tb_servo_ipd_mux.sv
// Testbench for servo_ipd_mux.
// dut_i : integral-only instance (KI=1.0) with NCH=5 so a 3-bit tag can carry
//         an out-of-range channel number.
// dut_p : proportional-only instance (KI=0, KP=1.0), NCH=4.
// Duty cycles are observed by counting pwm_out high cycles over one full
// 256-cycle frame after the shadow duty has had time to become active.

module tb_servo_ipd_mux;

`ifdef SERVO_IPD_DTERM_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        v0, rdy0, dn0, err0;
  logic [2:0]  ch0, dch0;
  logic [7:0]  ad0;
  logic [39:0] rb0;
  logic [4:0]  sat0, pwm0;

  logic        v1, rdy1, dn1, err1;
  logic [1:0]  ch1, dch1;
  logic [7:0]  ad1;
  logic [31:0] rb1;
  logic [3:0]  sat1, pwm1;

  servo_ipd_mux #(.NCH(5), .KI(256), .KP(0), .KD(0)) dut_i (
    .Clock_Nexys(clk), .Reset(rst_n),
    .adc_valid(v0), .adc_ready(rdy0), .adc_chan(ch0), .adc_data(ad0),
    .ref_bus(rb0), .done(dn0), .done_chan(dch0), .err_chan(err0),
    .sat(sat0), .pwm_out(pwm0)
  );

  servo_ipd_mux #(.NCH(4), .KI(0), .KP(256), .KD(0)) dut_p (
    .Clock_Nexys(clk), .Reset(rst_n),
    .adc_valid(v1), .adc_ready(rdy1), .adc_chan(ch1), .adc_data(ad1),
    .ref_bus(rb1), .done(dn1), .done_chan(dch1), .err_chan(err1),
    .sat(sat1), .pwm_out(pwm1)
  );

  int total = 0;
  int bad   = 0;
  int cnt0 [5];
  int cnt1 [4];

  typedef struct {
    int         ch;
    int         rf;
    int         ad;
    int         duty;
    logic [4:0] sat_exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endtask

  // One sample transaction; returns the number of negedges from the accept
  // edge until done is seen (-1 if never) and the reported channel.
  task automatic send(input int sel, input int ch, input int rf, input int ad,
                      output int lat, output int dch);
    int w;
    lat = -1;
    dch = -1;
    @(negedge clk);
    if (sel == 0) begin v0 = 1'b1; ch0 = 3'(ch); ad0 = 8'(ad); rb0[ch*8 +: 8] = 8'(rf); end
    else          begin v1 = 1'b1; ch1 = 2'(ch); ad1 = 8'(ad); rb1[ch*8 +: 8] = 8'(rf); end
    w = 0;
    while (!((sel == 0) ? rdy0 : rdy1) && w < 20) begin @(negedge clk); w++; end
    @(posedge clk);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      // Reference changes after LOAD must not affect this update.
      if (i == 2) begin
        if (sel == 0) rb0[ch*8 +: 8] = ~8'(rf);
        else          rb1[ch*8 +: 8] = ~8'(rf);
      end
      if ((sel == 0) ? dn0 : dn1) begin
        lat = i;
        dch = (sel == 0) ? int'(dch0) : int'(dch1);
        break;
      end
    end
    w = 0;
    while (!((sel == 0) ? rdy0 : rdy1) && w < 20) begin @(negedge clk); w++; end
  endtask

  task automatic measure();
    repeat (300) @(negedge clk);
    for (int c = 0; c < 5; c++) cnt0[c] = 0;
    for (int c = 0; c < 4; c++) cnt1[c] = 0;
    repeat (256) begin
      @(negedge clk);
      for (int c = 0; c < 5; c++) if (pwm0[c]) cnt0[c]++;
      for (int c = 0; c < 4; c++) if (pwm1[c]) cnt1[c]++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "timeout");
  end

  initial begin
    int lat, dch, nerr, ndone;
    int exp_duty [5];

    tbl[0] = '{2,   10, 128, 138, 5'b00000};
    tbl[1] = '{2,   10, 128, 148, 5'b00000};
    tbl[2] = '{0,  127,   0, 255, 5'b00001};
    tbl[3] = '{0,  127,   0, 255, 5'b00001};
    tbl[4] = '{0,  127,   0, 255, 5'b00001};
    tbl[5] = '{3,   -5, 128, 123, 5'b00001};
    tbl[6] = '{4,    0, 200,  56, 5'b00001};
    tbl[7] = '{1, -100, 255,   0, 5'b00011};
    for (int c = 0; c < 5; c++) exp_duty[c] = 128;

    rst_n = 1'b0;
    v0 = 1'b0; ch0 = '0; ad0 = 8'd128; rb0 = '0;
    v1 = 1'b0; ch1 = '0; ad1 = 8'd128; rb1 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwm0, 0);
    chk("rst_ready", rdy0, 1);
    chk("rst_sat", sat0, 0);
    chk("rst_done", dn0, 0);
    chk("rst_err", err0, 0);
    chk("rst_done_chan", dch0, 0);

    // Reset asserted mid-frame clears the outputs immediately
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("mid_frame_pwm_before", pwm0, 5'b11111);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", pwm0, 0);
    chk("async_rst_ready", rdy0, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    measure();
    for (int c = 0; c < 5; c++) chk($sformatf("rst_duty_ch%0d", c), cnt0[c], 128);
    chk("rst_duty_p_ch0", cnt1[0], 128);

    // Table-driven integrator / saturation vectors
    for (int k = 0; k < 8; k++) begin
      send(0, tbl[k].ch, tbl[k].rf, tbl[k].ad, lat, dch);
      exp_duty[tbl[k].ch] = tbl[k].duty;
      chk($sformatf("v%0d_latency", k), lat, LAT);
      chk($sformatf("v%0d_done_chan", k), dch, tbl[k].ch);
      measure();
      chk($sformatf("v%0d_duty_ch%0d", k, tbl[k].ch), cnt0[tbl[k].ch], tbl[k].duty);
      chk($sformatf("v%0d_sat", k), sat0, tbl[k].sat_exp);
    end

    // Bad tag: dropped, err pulse for one cycle, no update
    @(negedge clk);
    v0 = 1'b1; ch0 = 3'd5; ad0 = 8'd0;
    @(posedge clk);
    #1;
    v0 = 1'b0;
    @(negedge clk);
    chk("badtag_err_pulse", err0, 1);
    chk("badtag_ready", rdy0, 1);
    nerr = 0;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (err0) nerr++;
      if (dn0) ndone++;
    end
    chk("badtag_err_width", nerr, 0);
    chk("badtag_no_done", ndone, 0);
    measure();
    for (int c = 0; c < 5; c++) chk($sformatf("badtag_duty_ch%0d", c), cnt0[c], exp_duty[c]);

    // Proportional on measurement
    send(1, 1, 0, 128, lat, dch);
    chk("p1_latency", lat, LAT);
    chk("p1_done_chan", dch, 1);
    send(1, 1, 0, 138, lat, dch);
    chk("p2_latency", lat, LAT);
    chk("p2_done_chan", dch, 1);
    measure();
    chk("p_duty_ch1", cnt1[1], 118);
    chk("p_duty_ch0", cnt1[0], 128);
    chk("p_sat", sat1, 0);
    chk("p_err", err1, 0);

    // Reset during MUL_P of a ch2 update: no done, ch2 integrator cleared
    @(negedge clk);
    v0 = 1'b1; ch0 = 3'd2; ad0 = 8'd128; rb0[16 +: 8] = 8'd10;
    @(posedge clk);
    #1;
    v0 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midupd_ready", rdy0, 1);
    chk("midupd_done", dn0, 0);
    chk("midupd_sat", sat0, 0);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (dn0) ndone++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (dn0) ndone++;
    end
    chk("midupd_no_done", ndone, 0);
    send(0, 2, 10, 128, lat, dch);
    chk("midupd_next_latency", lat, LAT);
    measure();
    chk("midupd_duty_ch2", cnt0[2], 138);
    chk("midupd_duty_ch0", cnt0[0], 128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
